pipe_skid_stage: RTL and testbench



---
 rtl/pipe_skid_stage_pkg.sv | 21 ++
 rtl/pipe_reg_en.sv | 30 +++
 rtl/pipe_skid_stage.sv | 114 +++++++++++
 tb/tb_pipe_skid_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the skid-buffered pipeline stage.
// Covers bubble values, hold-bus encodings and the occupancy state encoding.
package pipe_skid_stage_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [7:0]  INT_NONE = 8'h00;

  localparam int HOLD_FLAG_BUS = 3;
  localparam logic [HOLD_FLAG_BUS-1:0] HOLD_NONE = 3'b000;
  localparam logic [HOLD_FLAG_BUS-1:0] HOLD_PC   = 3'b001;
  localparam logic [HOLD_FLAG_BUS-1:0] HOLD_IF   = 3'b010;
  localparam logic [HOLD_FLAG_BUS-1:0] HOLD_ID   = 3'b011;

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_reg_en.sv
// Width-parametrised register with enable and a synchronous load-default.
// The asynchronous active-low reset forces the same default value.
module pipe_reg_en #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  // clr wins over en so a flush or drain can never be overridden by a load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg <= RST_VAL;
    end else if (clr) begin
      q_reg <= RST_VAL;
    end else if (en) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/pipe_skid_stage.sv
// One pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// Slot 0 (main) drives the outputs directly; slot 1 (skid) absorbs one extra entry.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int                INST_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter int                INT_W      = 8,
  parameter int                HOLD_W     = 3,
  parameter int                HOLD_LEVEL = 1,
  parameter logic [INST_W-1:0] NOP_INST   = INST_W'(INST_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [INST_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic [INT_W-1:0]  int_flag_i,
  input  logic [HOLD_W-1:0] hold_flag_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [INT_W-1:0]  int_flag_o,
  output logic [1:0]        count_o
);

  localparam int BUN_W = INST_W + ADDR_W + INT_W;
  localparam logic [BUN_W-1:0] BUBBLE = {NOP_INST, {ADDR_W{1'b0}}, INT_W'(INT_NONE)};

  state_e             state_reg;
  logic               out_valid_reg;
  logic               hold;
  logic               push;
  logic               pop;
  logic [BUN_W-1:0]   in_bundle;
  logic [BUN_W-1:0]   slot_d [2];
  logic [BUN_W-1:0]   slot_q [2];
  logic [1:0]         slot_en;
  logic [1:0]         slot_clr;

  assign hold       = (hold_flag_i >= HOLD_W'(HOLD_LEVEL));
  assign in_ready_o = (state_reg != ST_FULL) && !hold && !flush_i;
  assign push       = in_valid_i && in_ready_o;
  assign pop        = out_valid_reg && out_ready_i && !hold;
  assign in_bundle  = {inst_i, inst_addr_i, int_flag_i};

  // Main is cleared when it drains so an empty stage shows the bubble.
  always_comb begin
    slot_d[0]   = (state_reg == ST_FULL) ? slot_q[1] : in_bundle;
    slot_en[0]  = ((state_reg == ST_EMPTY) && push) ||
                  ((state_reg == ST_ONE) && push && pop) ||
                  ((state_reg == ST_FULL) && pop);
    slot_clr[0] = flush_i || ((state_reg == ST_ONE) && pop && !push);
    slot_d[1]   = in_bundle;
    slot_en[1]  = (state_reg == ST_ONE) && push && !pop;
    slot_clr[1] = flush_i || ((state_reg == ST_FULL) && pop);
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      pipe_reg_en #(
        .W       (BUN_W),
        .RST_VAL (BUBBLE)
      ) u_slot (
        .clk (clk),
        .rst (rst),
        .en  (slot_en[gi]),
        .clr (slot_clr[gi]),
        .d   (slot_d[gi]),
        .q   (slot_q[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_EMPTY;
      out_valid_reg <= 1'b0;
    end else if (flush_i) begin
      state_reg     <= ST_EMPTY;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_EMPTY: if (push) begin
          state_reg     <= ST_ONE;
          out_valid_reg <= 1'b1;
        end
        ST_ONE: if (push && !pop) begin
          state_reg     <= ST_FULL;
          out_valid_reg <= 1'b1;
        end else if (pop && !push) begin
          state_reg     <= ST_EMPTY;
          out_valid_reg <= 1'b0;
        end
        ST_FULL: if (pop) begin
          state_reg     <= ST_ONE;
          out_valid_reg <= 1'b1;
        end
        default: begin
          state_reg     <= ST_EMPTY;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid_o = out_valid_reg;
  assign count_o     = state_reg;
  assign {inst_o, inst_addr_o, int_flag_o} = slot_q[0];

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed scenarios then random traffic, all
// outputs compared every cycle against a queue-based model of the stage.
module tb_pipe_skid_stage;

  localparam int HOLD_LEVEL = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [7:0]  intf;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] inst_i = '0;
  logic [31:0] inst_addr_i = '0;
  logic [7:0]  int_flag_i = '0;
  logic [2:0]  hold_flag_i = '0;
  logic        flush_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic [7:0]  int_flag_o;
  logic [1:0]  count_o;

  ent_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(
    .INST_W     (32),
    .ADDR_W     (32),
    .INT_W      (8),
    .HOLD_W     (3),
    .HOLD_LEVEL (HOLD_LEVEL),
    .NOP_INST   (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .inst_i      (inst_i),
    .inst_addr_i (inst_addr_i),
    .int_flag_i  (int_flag_i),
    .hold_flag_i (hold_flag_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .inst_o      (inst_o),
    .inst_addr_o (inst_addr_o),
    .int_flag_o  (int_flag_o),
    .count_o     (count_o)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Expected outputs follow from the model queue: head entry or the bubble.
  task automatic check_outputs(input string tag);
    ent_t head;
    logic exp_ready;
    head = (q.size() > 0) ? q[0] : '{inst: NOP, addr: 32'h0, intf: 8'h0};
    exp_ready = (q.size() < 2) && (hold_flag_i < 3'(HOLD_LEVEL)) && !flush_i;
    check_val({tag, ".in_ready"},  64'(in_ready_o),  64'(exp_ready));
    check_val({tag, ".out_valid"}, 64'(out_valid_o), 64'(q.size() > 0));
    check_val({tag, ".count"},     64'(count_o),     64'(q.size()));
    check_val({tag, ".inst"},      64'(inst_o),      64'(head.inst));
    check_val({tag, ".addr"},      64'(inst_addr_o), 64'(head.addr));
    check_val({tag, ".int"},       64'(int_flag_o),  64'(head.intf));
  endtask

  // Drive one cycle, check outputs before the edge, then advance the model.
  task automatic cycle(input string tag, input logic v, input logic [31:0] inst,
                       input logic [31:0] addr, input logic [7:0] intf,
                       input logic [2:0] hold, input logic fl, input logic ordy);
    logic stall, do_pop, do_push;
    in_valid_i  = v;
    inst_i      = inst;
    inst_addr_i = addr;
    int_flag_i  = intf;
    hold_flag_i = hold;
    flush_i     = fl;
    out_ready_i = ordy;
    #1;
    check_outputs(tag);
    stall   = (hold >= 3'(HOLD_LEVEL));
    do_pop  = (q.size() > 0) && ordy && !stall;
    do_push = v && (q.size() < 2) && !stall && !fl;
    @(posedge clk);
    if (fl) begin
      $display("%s: flush, %0d entries dropped", tag, q.size());
      q.delete();
    end else begin
      if (do_pop) begin
        $display("%s: pop addr=%08h inst=%08h int=%02h", tag, q[0].addr, q[0].inst, q[0].intf);
        void'(q.pop_front());
      end
      if (do_push) q.push_back('{inst: inst, addr: addr, intf: intf});
    end
    #1;
  endtask

  initial begin
    // Reset held across a couple of edges.
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Streaming at full throughput.
    cycle("stream0", 1, 32'h11, 32'h0, 8'h0, 3'd0, 0, 1);
    cycle("stream1", 1, 32'h22, 32'h4, 8'h0, 3'd0, 0, 1);
    cycle("stream2", 1, 32'h33, 32'h8, 8'h0, 3'd0, 0, 1);
    cycle("stream3", 0, 32'h0,  32'h0, 8'h0, 3'd0, 0, 1);
    cycle("stream4", 0, 32'h0,  32'h0, 8'h0, 3'd0, 0, 1);

    // Backpressure fills the skid, then drains in order.
    cycle("bp0", 1, 32'h44, 32'h10, 8'h0, 3'd0, 0, 0);
    cycle("bp1", 1, 32'h55, 32'h14, 8'h0, 3'd0, 0, 0);
    cycle("bp2", 1, 32'h66, 32'h18, 8'h0, 3'd0, 0, 0);
    cycle("bp3", 0, 32'h0,  32'h0,  8'h0, 3'd0, 0, 1);
    cycle("bp4", 0, 32'h0,  32'h0,  8'h0, 3'd0, 0, 1);
    cycle("bp5", 0, 32'h0,  32'h0,  8'h0, 3'd0, 0, 1);

    // Hold at the threshold freezes both sides; one below it does not.
    cycle("hold0", 1, 32'h77, 32'h20, 8'h0, 3'd0, 0, 0);
    for (int i = 0; i < 3; i++)
      cycle("hold_on", 1, 32'h88, 32'h24, 8'h0, 3'(HOLD_LEVEL), 0, 1);
    cycle("hold_off", 0, 32'h0, 32'h0, 8'h0, 3'd0, 0, 1);
    cycle("hold_idle", 0, 32'h0, 32'h0, 8'h0, 3'd0, 0, 1);
    cycle("below0", 1, 32'h99, 32'h28, 8'h0, 3'd0, 0, 0);
    cycle("below1", 0, 32'h0, 32'h0, 8'h0, 3'(HOLD_LEVEL - 1), 0, 1);
    cycle("below2", 0, 32'h0, 32'h0, 8'h0, 3'(HOLD_LEVEL - 1), 0, 1);

    // Flush in FULL drops both entries and the concurrent input.
    cycle("fl0", 1, 32'hA0, 32'h30, 8'h0, 3'd0, 0, 0);
    cycle("fl1", 1, 32'hA1, 32'h34, 8'h0, 3'd0, 0, 0);
    cycle("fl2", 1, 32'hA2, 32'h38, 8'h0, 3'd0, 1, 0);
    cycle("fl3", 0, 32'h0,  32'h0,  8'h0, 3'd0, 0, 1);
    cycle("fl4", 0, 32'h0,  32'h0,  8'h0, 3'd0, 0, 1);

    // Flush while holding.
    cycle("flh0", 1, 32'hB0, 32'h3C, 8'h0, 3'd0, 0, 0);
    cycle("flh1", 0, 32'h0,  32'h0,  8'h0, 3'd7, 1, 1);
    cycle("flh2", 0, 32'h0,  32'h0,  8'h0, 3'd0, 0, 1);

    // Interrupt flag travels with its instruction.
    cycle("int0", 1, 32'h0010_0093, 32'h40, 8'h05, 3'd0, 0, 0);
    cycle("int1", 0, 32'h0, 32'h0, 8'h0, 3'd0, 0, 1);
    cycle("int2", 0, 32'h0, 32'h0, 8'h0, 3'd0, 0, 1);

    // Asynchronous reset while FULL, asserted and released between edges.
    cycle("ar0", 1, 32'hC0, 32'h50, 8'h1, 3'd0, 0, 0);
    cycle("ar1", 1, 32'hC1, 32'h54, 8'h2, 3'd0, 0, 0);
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    #1;
    check_val("ar_full.count", 64'(count_o), 64'(2));
    rst = 1'b0;
    #1;
    q.delete();
    check_outputs("async_rst");
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    cycle("ar2", 0, 32'h0, 32'h0, 8'h0, 3'd0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [2:0] h;
      h = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      cycle("rnd", 1'($urandom_range(0, 3) != 0), $urandom, $urandom, 8'($urandom),
            h, 1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
